// File: rtl/alu_exec_stage.sv
// RISC-V execute stage: registers ALU result, zero flag and branch decision into the
// EX/MEM boundary behind valid/ready handshakes, with an optional bit-serial shifter.
module alu_exec_stage #(
  parameter int XLEN         = 32,
  parameter int TAG_W        = 5,
  parameter bit SERIAL_SHIFT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic             out_branch,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0011,
    OP_SLL  = 4'b0100, OP_SLT = 4'b0101, OP_XOR = 4'b0110, OP_SRL = 4'b0111,
    OP_SRA  = 4'b1000, OP_NOR = 4'b1001, OP_BEQ = 4'b1010, OP_BNE = 4'b1011,
    OP_SLTU = 4'b1100, OP_BLT = 4'b1101
  } op_e;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e            state, state_next;
  logic [XLEN-1:0]   acc, acc_step;
  logic [SHW-1:0]    cnt;
  logic [3:0]        sh_op;
  logic [TAG_W-1:0]  sh_tag;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   alu_res;
  logic              alu_br;
  logic              slot_free, accept, is_shift, start_shift, finish;

  assign shamt       = in_b[SHW-1:0];
  assign slot_free   = !out_valid || out_ready;
  assign in_ready    = !reset && !flush && (state == IDLE) && slot_free;
  assign accept      = in_valid && in_ready;
  assign is_shift    = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA);
  // Zero-distance shifts take the single-cycle path even in serial mode.
  assign start_shift = SERIAL_SHIFT && accept && is_shift && (shamt != '0);
  assign finish      = (state == SHIFT) && (cnt == SHW'(1)) && slot_free;

  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    case (in_op)
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_ADD:  alu_res = in_a + in_b;
      OP_SUB:  alu_res = in_a - in_b;
      OP_SLL:  alu_res = in_a << shamt;
      OP_SLT:  alu_res[0] = $signed(in_a) < $signed(in_b);
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SRL:  alu_res = in_a >> shamt;
      OP_SRA:  alu_res = $signed(in_a) >>> shamt;
      OP_NOR:  alu_res = ~(in_a | in_b);
      OP_BEQ:  begin alu_res[0] = (in_a == in_b); alu_br = alu_res[0]; end
      OP_BNE:  begin alu_res[0] = (in_a != in_b); alu_br = alu_res[0]; end
      OP_SLTU: alu_res[0] = in_a < in_b;
      OP_BLT:  begin alu_res[0] = $signed(in_a) < $signed(in_b); alu_br = alu_res[0]; end
      default: begin alu_res = '0; alu_br = 1'b0; end
    endcase
  end

  always_comb begin
    acc_step = acc;
    case (sh_op)
      OP_SLL:  acc_step = {acc[XLEN-2:0], 1'b0};
      OP_SRL:  acc_step = {1'b0, acc[XLEN-1:1]};
      OP_SRA:  acc_step = {acc[XLEN-1], acc[XLEN-1:1]};
      default: acc_step = acc;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_shift) state_next = SHIFT;
      SHIFT:   if (finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_branch <= 1'b0;
      out_tag    <= '0;
      acc        <= '0;
      cnt        <= '0;
      sh_op      <= '0;
      sh_tag     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (start_shift) begin
        acc    <= in_a;
        cnt    <= shamt;
        sh_op  <= in_op;
        sh_tag <= in_tag;
      end else if (accept) begin
        out_valid  <= 1'b1;
        out_result <= alu_res;
        out_zero   <= (alu_res == '0);
        out_branch <= alu_br;
        out_tag    <= in_tag;
      end else if (state == SHIFT) begin
        if (cnt > SHW'(1)) begin
          acc <= acc_step;
          cnt <= cnt - SHW'(1);
        end else if (slot_free) begin
          // Last shift bypasses acc and lands straight in the result register.
          out_valid  <= 1'b1;
          out_result <= acc_step;
          out_zero   <= (acc_step == '0);
          out_branch <= 1'b0;
          out_tag    <= sh_tag;
          cnt        <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: one barrel-shift and one serial-shift instance,
// directed scenarios followed by random traffic against a behavioural model.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        reset, flush, out_ready;
  logic        iv0, iv1;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_tag;

  logic        ir0, ov0, oz0, ob0, ir1, ov1, oz1, ob1;
  logic [31:0] or0, or1;
  logic [4:0]  ot0, ot1;

  logic        sel;
  int          npass = 0, nfail = 0, ntotal = 0;

  // Behavioural model state
  logic        mv, mzero, mbr, mbusy;
  logic [31:0] mres, pres;
  logic [4:0]  mtag, ptag;
  int          mcnt;

  always #5 clk = ~clk;

  alu_exec_stage #(.XLEN(32), .TAG_W(5), .SERIAL_SHIFT(1'b0)) u_bar (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(iv0), .in_ready(ir0),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(ov0), .out_ready(out_ready), .out_result(or0), .out_zero(oz0),
    .out_branch(ob0), .out_tag(ot0));

  alu_exec_stage #(.XLEN(32), .TAG_W(5), .SERIAL_SHIFT(1'b1)) u_ser (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(iv1), .in_ready(ir1),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(ov1), .out_ready(out_ready), .out_result(or1), .out_zero(oz1),
    .out_branch(ob1), .out_tag(ot1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s (dut=%0d) observed=%h expected=%h", tag, sel, obs, exp);
    end
  endtask

  // Result of one op from the ISA rules: {branch, result}
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    logic        br;
    br = 1'b0;
    case (op)
      4'd0:  t = a & b;
      4'd1:  t = a | b;
      4'd2:  t = a + b;
      4'd3:  t = a - b;
      4'd4:  t = a << b[4:0];
      4'd5:  t = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  t = a ^ b;
      4'd7:  t = a >> b[4:0];
      4'd8:  t = $signed(a) >>> b[4:0];
      4'd9:  t = ~(a | b);
      4'd10: begin t = (a == b) ? 32'd1 : 32'd0; br = t[0]; end
      4'd11: begin t = (a != b) ? 32'd1 : 32'd0; br = t[0]; end
      4'd12: t = (a < b) ? 32'd1 : 32'd0;
      4'd13: begin t = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; br = t[0]; end
      default: t = 32'd0;
    endcase
    return {br, t};
  endfunction

  task automatic cyc(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] tg, input logic rdy, input logic fl, input logic rst);
    logic        exp_rdy, acc, free;
    logic [32:0] r;
    int          n;
    in_op = op; in_a = a; in_b = b; in_tag = tg; out_ready = rdy; flush = fl; reset = rst;
    iv0 = sel ? 1'b0 : v;
    iv1 = sel ? v : 1'b0;
    #1;
    exp_rdy = !rst && !fl && !mbusy && (!mv || rdy);
    chk("in_ready", {31'b0, sel ? ir1 : ir0}, {31'b0, exp_rdy});
    acc  = v && exp_rdy;
    free = !mv || rdy;
    if (rst) begin
      mv = 0; mres = 0; mzero = 0; mbr = 0; mtag = 0; mbusy = 0; mcnt = 0;
    end else if (fl) begin
      mv = 0; mbusy = 0; mcnt = 0;
    end else begin
      if (mv && rdy) mv = 0;
      if (acc) begin
        r = ref_alu(op, a, b);
        n = int'(b[4:0]);
        if (sel && (op == 4'd4 || op == 4'd7 || op == 4'd8) && n != 0) begin
          mbusy = 1; mcnt = n; pres = r[31:0]; ptag = tg;
        end else begin
          mv = 1; mres = r[31:0]; mbr = r[32]; mzero = (r[31:0] == 0); mtag = tg;
        end
      end else if (mbusy) begin
        if (mcnt > 1) mcnt--;
        else if (free) begin
          mv = 1; mres = pres; mbr = 0; mzero = (pres == 0); mtag = ptag; mbusy = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", {31'b0, sel ? ov1 : ov0}, {31'b0, mv});
    if (mv || rst) begin
      chk("out_result", sel ? or1 : or0, mres);
      chk("out_zero",   {31'b0, sel ? oz1 : oz0}, {31'b0, mzero});
      chk("out_branch", {31'b0, sel ? ob1 : ob0}, {31'b0, mbr});
      chk("out_tag",    {27'b0, sel ? ot1 : ot0}, {27'b0, mtag});
    end
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, rdy, 1'b0, 1'b0);
  endtask

  task automatic rand_run(input int cycles, input logic shifty);
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < cycles; i++) begin
      op = 4'($urandom_range(0, 15));
      if (shifty && $urandom_range(0, 1) == 1) op = ($urandom_range(0, 2) == 0) ? 4'd4 : (($urandom_range(0, 1) == 0) ? 4'd7 : 4'd8);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = a;
        1: a = 32'h8000_0000 | a;
        2: b[4:0] = 5'($urandom_range(0, 5));
        default: ;
      endcase
      cyc($urandom_range(0, 3) != 0, op, a, b, 5'($urandom), $urandom_range(0, 3) != 0,
          $urandom_range(0, 31) == 0, 1'b0);
    end
  endtask

  initial begin
    reset = 1; flush = 0; out_ready = 0; iv0 = 0; iv1 = 0;
    in_op = 0; in_a = 0; in_b = 0; in_tag = 0;
    mv = 0; mres = 0; mzero = 0; mbr = 0; mtag = 0; mbusy = 0; mcnt = 0; pres = 0; ptag = 0;
    sel = 0;
    @(negedge clk);

    // ---- barrel-shift instance ----
    cyc(1'b1, 4'd2, 32'd1, 32'd1, 5'd1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    chk("reset_result", or0, 32'd0);
    cyc(1'b1, 4'd2, 32'hFFFF_FFFF, 32'd1, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("add_wrap", or0, 32'd0);
    chk("add_zero", {31'b0, oz0}, 32'd1);
    cyc(1'b1, 4'd3, 32'd5, 32'd7, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("sub", or0, 32'hFFFF_FFFE);
    cyc(1'b1, 4'd5, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("slt", or0, 32'd1);
    cyc(1'b1, 4'd12, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("sltu", or0, 32'd0);
    cyc(1'b1, 4'd13, 32'hFFFF_FFFD, 32'd2, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("blt_branch", {31'b0, ob0}, 32'd1);
    cyc(1'b1, 4'd11, 32'd9, 32'd9, 5'd8, 1'b1, 1'b0, 1'b0);
    chk("bne_branch", {31'b0, ob0}, 32'd0);
    // Stall: XOR held for three cycles while a new op waits
    cyc(1'b1, 4'd6, 32'hF0F0_0000, 32'h0FF0_1234, 5'd9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'd1, 32'h11, 32'h22, 5'd10, 1'b0, 1'b0, 1'b0);
    chk("stall_hold", or0, 32'hFF00_1234);
    cyc(1'b1, 4'd1, 32'h11, 32'h22, 5'd10, 1'b1, 1'b0, 1'b0);
    chk("stall_release", or0, 32'h33);
    // Flush while a result is held
    cyc(1'b1, 4'd9, 32'h0, 32'h0, 5'd11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'd2, 32'd1, 32'd2, 5'd12, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    cyc(1'b1, 4'd8, 32'h8000_0000, 32'd4, 5'd13, 1'b1, 1'b0, 1'b0);
    chk("barrel_sra", or0, 32'hF800_0000);
    rand_run(400, 1'b0);

    // ---- serial-shift instance ----
    sel = 1;
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 4'd8, 32'h8000_0000, 32'd4, 5'd14, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'd2, 32'd1, 32'd1, 5'd1, 1'b1, 1'b0, 1'b0);
    chk("sra_not_early", {31'b0, ov1}, 32'd0);
    idle(1'b1);
    chk("sra_latency", {31'b0, ov1}, 32'd1);
    chk("sra_result", or1, 32'hF800_0000);
    cyc(1'b1, 4'd4, 32'h1234, 32'd0, 5'd15, 1'b1, 1'b0, 1'b0);
    chk("shamt0", or1, 32'h1234);
    // Flush mid-shift with cnt==2
    cyc(1'b1, 4'd7, 32'hFFFF_0000, 32'd3, 5'd16, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    // Reset mid-shift
    cyc(1'b1, 4'd8, 32'hC000_0000, 32'd5, 5'd17, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    rand_run(600, 1'b1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
